// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared Gray/binary helpers and depth helper for the async FIFO controllers
package async_fifo_pkg;

    // Widest pointer the helpers handle; narrower pointers are zero-extended by callers
    localparam int unsigned PTR_MAX_W = 32;

    // FIFO depth for a pointer whose MSB is the wrap bit
    function automatic int unsigned fifo_depth(input int unsigned ptr_size);
        return 32'd1 << (ptr_size - 1);
    endfunction

    // Binary to reflected Gray code
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary (XOR prefix from the MSB down)
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter (XOR prefix)
module fifo_gray2bin #(
    parameter int PTR_SIZE = 4
) (
    input  logic [PTR_SIZE-1:0] gray,
    output logic [PTR_SIZE-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        bin = '0;
        bin[PTR_SIZE-1] = gray[PTR_SIZE-1];
        for (int i = PTR_SIZE - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - async FIFO write-side pointer/full controller; optional fill level under ASYNC_FIFO_WR_LEVEL_EN
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int PTR_SIZE = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [PTR_SIZE-1:0] wq2_gray_rptr,
    output logic                wen,
    output logic [PTR_SIZE-2:0] waddr,
    output logic [PTR_SIZE-1:0] gray_wr_ptr,
    output logic                wfull,
    output logic                woverflow,
    output logic [PTR_SIZE-1:0] wlevel,
    output logic                walmost_full
);

    localparam int DEPTH = int'(fifo_depth(PTR_SIZE));

    // The full pattern flips the top two Gray bits, so at least three pointer bits are needed
    if (PTR_SIZE < 3) begin : g_bad_ptr_size
        $error("async_fifo_wr_ctrl: PTR_SIZE must be at least 3");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("async_fifo_wr_ctrl: AF_LEVEL must be within 1..DEPTH");
    end

    logic [PTR_SIZE-1:0] bn_wptr;
    logic [PTR_SIZE-1:0] bn_next;
    logic [PTR_SIZE-1:0] gray_next;
    logic [PTR_SIZE-1:0] full_pattern;
    logic                full_next;

    assign wen   = winc & ~wfull & ~wrst;
    assign waddr = bn_wptr[PTR_SIZE-2:0];

    // Next pointer and full flag, looking at the pointer after this edge and the current synchronised read pointer
    always_comb begin
        bn_next      = bn_wptr + {{(PTR_SIZE-1){1'b0}}, wen};
        gray_next    = PTR_SIZE'(bin2gray(PTR_MAX_W'(bn_next)));
        full_pattern = {~wq2_gray_rptr[PTR_SIZE-1:PTR_SIZE-2], wq2_gray_rptr[PTR_SIZE-3:0]};
        full_next    = (gray_next == full_pattern);
    end

    // Pointer, full and sticky overflow registers; reset wins over any write on the same edge
    always_ff @(posedge wclk) begin
        if (wrst) begin
            bn_wptr     <= '0;
            gray_wr_ptr <= '0;
            wfull       <= 1'b0;
            woverflow   <= 1'b0;
        end else begin
            bn_wptr     <= bn_next;
            gray_wr_ptr <= gray_next;
            wfull       <= full_next;
            woverflow   <= woverflow | (winc & wfull);
        end
    end

`ifdef ASYNC_FIFO_WR_LEVEL_EN
    logic [PTR_SIZE-1:0] rbin;
    logic [PTR_SIZE-1:0] level_next;

    fifo_gray2bin #(
        .PTR_SIZE (PTR_SIZE)
    ) u_rptr_g2b (
        .gray (wq2_gray_rptr),
        .bin  (rbin)
    );

    // Occupancy after this edge; modular subtraction handles the wrap bit
    always_comb begin
        level_next = bn_next - rbin;
    end

    // Registered level and almost-full, pessimistic like wfull because rbin lags the reader
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= PTR_SIZE'(AF_LEVEL));
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - scoreboard testbench for async_fifo_wr_ctrl (level checks follow ASYNC_FIFO_WR_LEVEL_EN)
module tb_async_fifo_wr_ctrl;

    localparam int PTR_SIZE = 4;
    localparam int AF_LEVEL = 6;
    localparam int DEPTH    = 8;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [3:0] wq2_gray_rptr;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] gray_wr_ptr;
    logic       wfull;
    logic       woverflow;
    logic [3:0] wlevel;
    logic       walmost_full;

    async_fifo_wr_ctrl #(
        .PTR_SIZE (PTR_SIZE),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .winc          (winc),
        .wq2_gray_rptr (wq2_gray_rptr),
        .wen           (wen),
        .waddr         (waddr),
        .gray_wr_ptr   (gray_wr_ptr),
        .wfull         (wfull),
        .woverflow     (woverflow),
        .wlevel        (wlevel),
        .walmost_full  (walmost_full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       chk_addr;
        logic       wen;
        logic [2:0] waddr;
    } pre_t;

    typedef struct {
        logic [3:0] gray;
        logic       full;
        logic       ovf;
        logic [3:0] lvl;
        logic       af;
    } post_t;

    pre_t  pre_q[$];
    post_t post_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: write count, reader position in binary, occupancy-based full
    int m_wcnt = 0;
    int m_ovf  = 0;
    int m_full = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One wclk cycle: drive, check combinational outputs, clock, check registered outputs
    task automatic step(input logic inc, input logic rst, input int rptr_bin);
        pre_t  pe;
        post_t po;
        pre_t  pg;
        post_t pog;
        int    occ;
        logic [3:0] rb;
        logic [3:0] wb;

        rb = 4'(rptr_bin);
        winc          = inc;
        wrst          = rst;
        wq2_gray_rptr = rb ^ (rb >> 1);

        pe.chk_addr = !rst;
        pe.wen      = inc && (m_full == 0) && !rst;
        pe.waddr    = 3'(m_wcnt % DEPTH);
        pre_q.push_back(pe);

        if (rst) begin
            m_wcnt = 0;
            m_ovf  = 0;
            m_full = 0;
            po.lvl = 4'd0;
            po.af  = 1'b0;
        end else begin
            if (inc && m_full != 0) m_ovf = 1;
            if (pe.wen) m_wcnt = (m_wcnt + 1) % 16;
            occ    = (m_wcnt - rptr_bin + 16) % 16;
            m_full = (occ == DEPTH) ? 1 : 0;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
            po.lvl = 4'(occ);
            po.af  = (occ >= AF_LEVEL);
`else
            po.lvl = 4'd0;
            po.af  = 1'b0;
`endif
        end
        wb      = 4'(m_wcnt);
        po.gray = wb ^ (wb >> 1);
        po.full = (m_full != 0);
        po.ovf  = (m_ovf != 0);
        post_q.push_back(po);

        #1;
        pg = pre_q.pop_front();
        check("wen", 32'(wen), 32'(pg.wen));
        if (pg.chk_addr) check("waddr", 32'(waddr), 32'(pg.waddr));

        @(posedge wclk);
        #1;
        pog = post_q.pop_front();
        check("gray_wr_ptr", 32'(gray_wr_ptr), 32'(pog.gray));
        check("wfull", 32'(wfull), 32'(pog.full));
        check("woverflow", 32'(woverflow), 32'(pog.ovf));
        check("wlevel", 32'(wlevel), 32'(pog.lvl));
        check("walmost_full", 32'(walmost_full), 32'(pog.af));
        @(negedge wclk);
    endtask

    logic [3:0] gray_seq [8];

    initial begin
        gray_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        winc = 1'b0;
        wrst = 1'b1;
        wq2_gray_rptr = 4'h0;
        @(negedge wclk);

        // Reset held with winc asserted
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        check("reset_waddr", 32'(waddr), 32'd0);

        // Fill eight entries against an idle reader
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0);
            check("fill_gray_seq", 32'(gray_wr_ptr), 32'(gray_seq[i]));
        end
        check("fill_full", 32'(wfull), 32'd1);

        // Keep writing while full
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
        check("ovf_gray_hold", 32'(gray_wr_ptr), 32'hC);
        check("ovf_sticky", 32'(woverflow), 32'd1);

        // Reader catches up to binary 8 (Gray 1100), then wrap-around fill
        step(1'b0, 1'b0, 8);
        check("wrap_unfull", 32'(wfull), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8);
        check("wrap_gray_zero", 32'(gray_wr_ptr), 32'h0);
        check("wrap_full", 32'(wfull), 32'd1);
        step(1'b1, 1'b0, 8);

        // Reset pulse mid-operation with both controllers restarting
        step(1'b1, 1'b1, 0);
        check("midrst_full", 32'(wfull), 32'd0);
        check("midrst_ovf", 32'(woverflow), 32'd0);

        // Six writes then reader advances by two
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 2);

        // Randomised tail: reader never passes writer, never more than DEPTH behind
        begin
            int rp;
            rp = 2;
            for (int i = 0; i < 40; i++) begin
                int occ;
                occ = (m_wcnt - rp + 16) % 16;
                if (occ > 0 && $urandom_range(0, 2) == 0) rp = (rp + 1) % 16;
                step(1'($urandom_range(0, 1)), 1'b0, rp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
